mulf_seq: RTL and testbench

MULF_SEQ -- requirements
Module: mulf_seq

---
 rtl/mulf_seq.sv | 186 ++++++++++++++++++
 tb/tb_mulf_seq.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mulf_seq.sv
// Sequential IEEE-style floating-point multiplier: one multiplier bit per cycle,
// round-to-nearest-even, flush-to-zero inputs and outputs, ready/valid handshakes.
module mulf_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] s
);

  localparam int SM    = MAN_W + 1;
  localparam int EW2   = EXP_W + 2;
  localparam int CNT_W = $clog2(SM + 1);
  localparam logic signed [EW2-1:0] BIAS = EW2'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW2-1:0] EMAX = EW2'((1 << EXP_W) - 1);

  typedef enum logic [1:0] {IDLE, MUL, RND, DONE} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [SM-1:0]           ma_q, ma_d;
  logic [SM-1:0]           hi_q, hi_d;
  logic [SM-1:0]           lo_q, lo_d;
  logic signed [EW2-1:0]   exp_q, exp_d;
  logic                    sign_q, sign_d;
  logic [W-1:0]            s_q, s_d;
  logic                    out_valid_q, out_valid_d;
  logic                    in_ready_q, in_ready_d;

  logic [SM:0]             sum;
  logic signed [EW2-1:0]   ea_s, eb_s;
  logic                    a_ones, b_ones, a_zero, b_zero, a_nan, b_nan, a_inf, b_inf;
  logic                    sgn_in;

  // Normalise the 2*SM-bit significand product, round to nearest even, then
  // saturate to infinity or flush to zero based on the final exponent.
  function automatic logic [W-1:0] round_pack(input logic [2*SM-1:0]     prod,
                                              input logic signed [EW2-1:0] e_in,
                                              input logic                  sgn);
    logic [SM-1:0]         m;
    logic [SM:0]           mr;
    logic                  g, st, rup;
    logic signed [EW2-1:0] ef;
    if (prod[2*SM-1]) begin
      m  = prod[2*SM-1:SM];
      g  = prod[SM-1];
      st = |prod[SM-2:0];
      ef = e_in + EW2'(1);
    end else begin
      m  = prod[2*SM-2:SM-1];
      g  = prod[SM-2];
      st = |prod[SM-3:0];
      ef = e_in;
    end
    rup = g & (st | m[0]);
    mr  = {1'b0, m} + (SM+1)'(rup);
    if (mr[SM]) begin
      m  = mr[SM:1];
      ef = ef + EW2'(1);
    end else begin
      m  = mr[SM-1:0];
    end
    if (ef >= EMAX)
      round_pack = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (ef[EW2-1] || (ef == '0))
      round_pack = {sgn, {(W-1){1'b0}}};
    else
      round_pack = {sgn, ef[EXP_W-1:0], m[MAN_W-1:0]};
  endfunction

  assign a_ones = &a[W-2:MAN_W];
  assign b_ones = &b[W-2:MAN_W];
  assign a_zero = ~|a[W-2:MAN_W];
  assign b_zero = ~|b[W-2:MAN_W];
  assign a_nan  = a_ones & (|a[MAN_W-1:0]);
  assign b_nan  = b_ones & (|b[MAN_W-1:0]);
  assign a_inf  = a_ones & ~(|a[MAN_W-1:0]);
  assign b_inf  = b_ones & ~(|b[MAN_W-1:0]);
  assign sgn_in = a[W-1] ^ b[W-1];
  assign ea_s   = {2'b00, a[W-2:MAN_W]};
  assign eb_s   = {2'b00, b[W-2:MAN_W]};

  // Shift-add step: the low half holds the unconsumed multiplier bits and
  // collects product bits as the partial sum shifts right.
  assign sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, ma_q} : {(SM+1){1'b0}});

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ma_d        = ma_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    exp_d       = exp_q;
    sign_d      = sign_q;
    s_d         = s_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d     = sgn_in;
          in_ready_d = 1'b0;
          if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            s_d         = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else if (a_inf || b_inf) begin
            s_d         = {sgn_in, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else if (a_zero || b_zero) begin
            s_d         = {sgn_in, {(W-1){1'b0}}};
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            ma_d    = {1'b1, a[MAN_W-1:0]};
            lo_d    = {1'b1, b[MAN_W-1:0]};
            hi_d    = '0;
            cnt_d   = '0;
            exp_d   = ea_s + eb_s - BIAS;
            state_d = MUL;
          end
        end
      end
      MUL: begin
        hi_d  = sum[SM:1];
        lo_d  = {sum[0], lo_q[SM-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(SM - 1))
          state_d = RND;
      end
      RND: begin
        s_d         = round_pack({hi_q, lo_q}, exp_q, sign_q);
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ma_q        <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      exp_q       <= '0;
      sign_q      <= 1'b0;
      s_q         <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ma_q        <= ma_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      exp_q       <= exp_d;
      sign_q      <= sign_d;
      s_q         <= s_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign s         = s_q;

endmodule

// File: tb/tb_mulf_seq.sv
// Directed-vector and reference-model bench for mulf_seq at default single-precision widths.
module tb_mulf_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] s;

  int checks = 0;
  int errors = 0;

  mulf_seq #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .s(s)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] s;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, got, exp);
    end
  endtask

  task automatic timeout_fail(input string name, input int idx);
    checks++;
    errors++;
    $display("FAIL %s[%0d]: timed out waiting for DUT", name, idx);
  endtask

  // Independent single-precision model: exact integer product, remainder-vs-half RNE.
  function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    longint unsigned mx, my, p, m, rem, half;
    int e, sh;
    logic sg;
    sg = x[31] ^ y[31];
    mx = {40'd0, 1'b1, x[22:0]};
    my = {40'd0, 1'b1, y[22:0]};
    p  = mx * my;
    e  = int'(x[30:23]) + int'(y[30:23]) - 127;
    sh = p[47] ? 24 : 23;
    if (p[47]) e++;
    m    = p >> sh;
    rem  = p & ((64'd1 << sh) - 64'd1);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && m[0])) m++;
    if (m == (64'd1 << 24)) begin
      m = m >> 1;
      e++;
    end
    if (e >= 255) return {sg, 8'hFF, 23'd0};
    if (e <= 0)   return {sg, 31'd0};
    return {sg, e[7:0], m[22:0]};
  endfunction

  // Issue one operation, measure accept-to-valid latency, then hand off.
  task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input bit rand_rdy,
                        output logic [31:0] res, output int lat, output bit ok);
    int g;
    ok  = 1'b0;
    res = '0;
    lat = 0;
    @(negedge clk);
    g = 0;
    while (!in_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) return;
    in_valid  = 1'b1;
    a         = av;
    b         = bv;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) return;
    res = s;
    g = 0;
    do begin
      @(negedge clk);
      out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk);
      #1;
      g++;
    end while (!out_ready && g < 50);
    out_ready = 1'b0;
    ok = 1'b1;
  endtask

  initial begin
    vec_t        vt[9];
    logic [31:0] res, held, ra, rb;
    int          lat, cnt;
    bit          ok;

    vt[0] = '{32'h3FC00000, 32'h40000000, 32'h40400000, 26};
    vt[1] = '{32'hC0000000, 32'h3F000000, 32'hBF800000, 26};
    vt[2] = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 26};
    vt[3] = '{32'h7F000000, 32'h7F000000, 32'h7F800000, 26};
    vt[4] = '{32'h00800000, 32'h00800000, 32'h00000000, 26};
    vt[5] = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 1};
    vt[6] = '{32'hFF800000, 32'h40000000, 32'hFF800000, 1};
    vt[7] = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1};
    vt[8] = '{32'h80000000, 32'h3F800000, 32'h80000000, 1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", 0, 32'(in_ready), 32'd1);
    chk("reset_out_valid", 0, 32'(out_valid), 32'd0);
    chk("reset_s", 0, s, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_op(vt[i].a, vt[i].b, 1'b0, res, lat, ok);
      if (!ok) begin
        timeout_fail("vec", i);
      end else begin
        chk("vec_s", i, res, vt[i].s);
        chk("vec_latency", i, 32'(lat), 32'(vt[i].lat));
      end
    end

    // Backpressure: result and flags hold, new operands are ignored.
    @(negedge clk);
    in_valid = 1'b1; a = 32'h3FC00000; b = 32'h40000000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cnt = 0;
    while (!out_valid && cnt < 100) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    if (!out_valid) timeout_fail("bp_wait", 0);
    held = s;
    chk("bp_first_s", 0, held, 32'h40400000);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = 1'b1; a = 32'h40000000 + 32'(k); b = 32'h40400000;
      @(posedge clk);
      #1;
      chk("bp_out_valid", k, 32'(out_valid), 32'd1);
      chk("bp_s_stable", k, s, held);
      chk("bp_in_ready", k, 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_in_ready", 0, 32'(in_ready), 32'd1);
    chk("bp_release_out_valid", 0, 32'(out_valid), 32'd0);
    @(negedge clk);
    out_ready = 1'b0;

    // Reset in the middle of the multiply discards the operation.
    in_valid = 1'b1; a = 32'h3FC00000; b = 32'h40000000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_out_valid", 0, 32'(out_valid), 32'd0);
    chk("midrst_s", 0, s, 32'd0);
    chk("midrst_in_ready", 0, 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) cnt++;
    end
    chk("midrst_no_output", 0, 32'(cnt), 32'd0);
    run_op(32'h3FC00000, 32'h40000000, 1'b0, res, lat, ok);
    if (!ok) timeout_fail("midrst_after", 0);
    else begin
      chk("midrst_after_s", 0, res, 32'h40400000);
      chk("midrst_after_latency", 0, 32'(lat), 32'd26);
    end

    // Random normal operands with random consumer stalls.
    for (int i = 0; i < 100; i++) begin
      ra = {1'($urandom_range(0, 1)), 8'($urandom_range(90, 160)), 23'($urandom)};
      rb = {1'($urandom_range(0, 1)), 8'($urandom_range(90, 160)), 23'($urandom)};
      run_op(ra, rb, 1'b1, res, lat, ok);
      if (!ok) timeout_fail("rand", i);
      else chk("rand_s", i, res, ref_mul(ra, rb));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
